// File: rtl/axi_wr_pkg.sv
// -----------------------------------------------------------------------------
// axi_wr_pkg
// Shared types and helpers for the AXI4-Lite write router and its decoder.
//   resp_t      : AXI write response codes (OKAY / SLVERR / DECERR)
//   wr_state_t  : write-path FSM states
//   STRB_W      : strobe width for the default 32-bit data bus
//   idx_width() : width of a channel index for a given channel count
//   sat_inc16() : saturating 16-bit increment
// -----------------------------------------------------------------------------
package axi_wr_pkg;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned STRB_W     = DEF_DATA_W / 8;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [1:0] {
      IDLE,
      DECODE,
      PUSH,
      RESP
   } wr_state_t;

   // A single channel still needs a 1-bit index signal.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/axi_lite_wr_router_if.sv
// -----------------------------------------------------------------------------
// axi_lite_wr_router_if
// AXI4-Lite write-channel bundle (AW, W, B). No read channels.
//   AWADDR/AWVALID/AWREADY : write address channel
//   WDATA/WSTRB/WVALID/WREADY : write data channel
//   BRESP/BVALID/BREADY    : write response channel
// Modports: master (interconnect side), slave (router side).
// -----------------------------------------------------------------------------
interface axi_lite_wr_router_if #(
   parameter int unsigned ADDR_W = axi_wr_pkg::DEF_ADDR_W,
   parameter int unsigned DATA_W = axi_wr_pkg::DEF_DATA_W
);

   logic [ADDR_W-1:0]   AWADDR;
   logic                AWVALID;
   logic                AWREADY;
   logic [DATA_W-1:0]   WDATA;
   logic [DATA_W/8-1:0] WSTRB;
   logic                WVALID;
   logic                WREADY;
   logic [1:0]          BRESP;
   logic                BVALID;
   logic                BREADY;

   modport master (
      output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      input  AWREADY, WREADY, BRESP, BVALID
   );

   modport slave (
      input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      output AWREADY, WREADY, BRESP, BVALID
   );

endinterface

// File: rtl/axi_wr_decode.sv
// -----------------------------------------------------------------------------
// axi_wr_decode
// Purely combinational address/strobe decoder shared by the write router and
// the planned read-side router.
//   addr_i    in  ADDR_W    byte address
//   strb_i    in  DATA_W/8  byte strobes
//   idx_o     out IDX_W     channel index (valid only when hit_o)
//   hit_o     out 1         address is at/above BASE_ADDR, stride-aligned and
//                           selects an existing channel
//   strb_ok_o out 1         all strobe bits set (full-word write)
// -----------------------------------------------------------------------------
module axi_wr_decode
   import axi_wr_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       NUM_CH    = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned       CH_STRIDE = 4,
   localparam int unsigned      IDX_W     = idx_width(NUM_CH)
) (
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W/8-1:0] strb_i,
   output logic [IDX_W-1:0]    idx_o,
   output logic                hit_o,
   output logic                strb_ok_o
);

   localparam int unsigned       STRIDE_SH   = $clog2(CH_STRIDE);
   localparam logic [ADDR_W-1:0] STRIDE_MASK = ADDR_W'(CH_STRIDE - 1);
   localparam logic [ADDR_W-1:0] NUM_CH_A    = ADDR_W'(NUM_CH);

   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] slot;

   // Below-base addresses wrap to huge offsets; they are rejected explicitly
   // so the decision never depends on that wrap.
   assign offset    = addr_i - BASE_ADDR;
   assign slot      = offset >> STRIDE_SH;
   assign hit_o     = (addr_i >= BASE_ADDR) &&
                      ((offset & STRIDE_MASK) == '0) &&
                      (slot < NUM_CH_A);
   assign idx_o     = slot[IDX_W-1:0];
   assign strb_ok_o = &strb_i;

endmodule

// File: rtl/axi_lite_wr_router.sv
// -----------------------------------------------------------------------------
// axi_lite_wr_router
// AXI4-Lite write-only slave that pushes each accepted full-word write into one
// of NUM_CH downstream FIFOs selected by address, then answers on B.
//   ACLK      in  1        clock, rising edge
//   ARESET    in  1        synchronous reset, active-high
//   s_axi     slave        AW / W / B channels
//   ch_full   in  NUM_CH   per-channel FIFO full
//   ch_wr_en  out NUM_CH   push strobe, one-hot or zero
//   ch_wdata  out DATA_W   push data, shared by all channels
//   err_count out 16       saturating count of non-OKAY responses
// AW and W are captured independently; once both are held the FSM walks
// IDLE -> DECODE -> PUSH -> RESP (errors skip PUSH). A full FIFO stalls PUSH
// for at most TIMEOUT cycles (0 = forever) before answering SLVERR.
// -----------------------------------------------------------------------------
module axi_lite_wr_router
   import axi_wr_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       NUM_CH    = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned       CH_STRIDE = 4,
   parameter int unsigned       TIMEOUT   = 256
) (
   input  logic                ACLK,
   input  logic                ARESET,
   axi_lite_wr_router_if.slave s_axi,
   input  logic [NUM_CH-1:0]   ch_full,
   output logic [NUM_CH-1:0]   ch_wr_en,
   output logic [DATA_W-1:0]   ch_wdata,
   output logic [15:0]         err_count
);

   localparam int unsigned NBYTES = DATA_W / 8;
   localparam int unsigned IDX_W  = idx_width(NUM_CH);
   localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   wr_state_t         state_q,     state_d;
   logic              aw_held_q,   aw_held_d;
   logic              w_held_q,    w_held_d;
   logic [ADDR_W-1:0] addr_q,      addr_d;
   logic [DATA_W-1:0] data_q,      data_d;
   logic [NBYTES-1:0] strb_q,      strb_d;
   logic [IDX_W-1:0]  idx_q,       idx_d;
   resp_t             resp_q,      resp_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [15:0]       err_cnt_q,   err_cnt_d;

   logic              aw_hs, w_hs, b_hs;
   logic [IDX_W-1:0]  dec_idx;
   logic              dec_hit, dec_strb_ok;
   logic [NUM_CH-1:0] sel_oh;
   logic              full_sel;
   logic              push;

   axi_wr_decode #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .NUM_CH    (NUM_CH),
      .BASE_ADDR (BASE_ADDR),
      .CH_STRIDE (CH_STRIDE)
   ) u_decode (
      .addr_i    (addr_q),
      .strb_i    (strb_q),
      .idx_o     (dec_idx),
      .hit_o     (dec_hit),
      .strb_ok_o (dec_strb_ok)
   );

   // Ready depends on registers only, so no VALID->READY combinational path.
   assign s_axi.AWREADY = (state_q == IDLE) && !aw_held_q;
   assign s_axi.WREADY  = (state_q == IDLE) && !w_held_q;
   assign s_axi.BVALID  = (state_q == RESP);
   assign s_axi.BRESP   = resp_q;

   assign aw_hs = s_axi.AWVALID && s_axi.AWREADY;
   assign w_hs  = s_axi.WVALID  && s_axi.WREADY;
   assign b_hs  = s_axi.BVALID  && s_axi.BREADY;

   always_comb begin
      sel_oh = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (idx_q == IDX_W'(i)) sel_oh[i] = 1'b1;
      end
   end

   // Full gating is same-cycle: the push fires in the very cycle full drops.
   assign full_sel  = |(ch_full & sel_oh);
   assign push      = (state_q == PUSH) && !full_sel;
   assign ch_wr_en  = push ? sel_oh : '0;
   assign ch_wdata  = data_q;
   assign err_count = err_cnt_q;

   always_comb begin
      // NOTE: every _d starts as its _q so each path assigns it; no latches.
      state_d     = state_q;
      aw_held_d   = aw_held_q;
      w_held_d    = w_held_q;
      addr_d      = addr_q;
      data_d      = data_q;
      strb_d      = strb_q;
      idx_d       = idx_q;
      resp_d      = resp_q;
      stall_cnt_d = stall_cnt_q;
      err_cnt_d   = err_cnt_q;

      if (aw_hs) begin
         addr_d    = s_axi.AWADDR;
         aw_held_d = 1'b1;
      end
      if (w_hs) begin
         data_d   = s_axi.WDATA;
         strb_d   = s_axi.WSTRB;
         w_held_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (aw_held_q && w_held_q) state_d = DECODE;
         end
         DECODE: begin
            // Address errors take priority over strobe errors.
            if (!dec_hit) begin
               resp_d  = DECERR;
               state_d = RESP;
            end else if (!dec_strb_ok) begin
               resp_d  = SLVERR;
               state_d = RESP;
            end else begin
               idx_d   = dec_idx;
               state_d = PUSH;
            end
         end
         PUSH: begin
            if (!full_sel) begin
               resp_d  = OKAY;
               state_d = RESP;
            end else begin
               stall_cnt_d = stall_cnt_q + CNT_W'(1);
               if ((TIMEOUT != 0) && (stall_cnt_d == CNT_W'(TIMEOUT))) begin
                  resp_d  = SLVERR;
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            if (b_hs) begin
               aw_held_d   = 1'b0;
               w_held_d    = 1'b0;
               stall_cnt_d = '0;
               state_d     = IDLE;
               if (resp_q != OKAY) err_cnt_d = sat_inc16(err_cnt_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= IDLE;
         aw_held_q   <= 1'b0;
         w_held_q    <= 1'b0;
         // NOTE: datapath registers are reset as well; ch_wdata reads 0 out of reset.
         addr_q      <= '0;
         data_q      <= '0;
         strb_q      <= '0;
         idx_q       <= '0;
         resp_q      <= OKAY;
         stall_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of the others.
         state_q     <= state_d;
         aw_held_q   <= aw_held_d;
         w_held_q    <= w_held_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         strb_q      <= strb_d;
         idx_q       <= idx_d;
         resp_q      <= resp_d;
         stall_cnt_q <= stall_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_axi_lite_wr_router.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_wr_router
// Directed bench: a table of single writes (address, data, strobe, FIFO-full
// pattern -> expected push vector and response), then hand-written sequences
// for early W, FIFO stall/timeout, BREADY back-pressure and mid-transaction
// reset. Outputs are sampled on the falling edge; inputs change there too.
// Cycle numbering: k=1 is the cycle after the last AW/W handshake.
// -----------------------------------------------------------------------------
module tb_axi_lite_wr_router;
   import axi_wr_pkg::*;

   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          LIMIT = 400;

   logic        ACLK   = 1'b0;
   logic        ARESET = 1'b1;
   logic [3:0]  ch_full = 4'b0000;
   logic [3:0]  ch_wr_en;
   logic [31:0] ch_wdata;
   logic [15:0] err_count;

   int checks = 0;
   int errors = 0;
   int err_exp = 0;

   // results of the most recent monitor() call
   logic [3:0]  m_vec;
   logic [31:0] m_data;
   logic [1:0]  m_resp;
   int          m_pcnt, m_pcyc, m_bcyc, m_bad;

   typedef struct {
      logic [3:0]  full;
      logic [31:0] addr;
      logic [31:0] data;
      logic [STRB_W-1:0] strb;
      logic [3:0]  exp_vec;
      resp_t       exp_resp;
   } vec_t;

   vec_t vecs [11];

   axi_lite_wr_router_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   axi_lite_wr_router #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .NUM_CH    (4),
      .BASE_ADDR (BASE),
      .CH_STRIDE (4),
      .TIMEOUT   (256)
   ) dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .s_axi     (bus.slave),
      .ch_full   (ch_full),
      .ch_wr_en  (ch_wr_en),
      .ch_wdata  (ch_wdata),
      .err_count (err_count)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no summary, required summary");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Called at a falling edge with the router idle; both channels handshake
   // on the next rising edge.
   task automatic start_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
      bus.AWADDR  = addr;
      bus.AWVALID = 1'b1;
      bus.WDATA   = data;
      bus.WSTRB   = strb;
      bus.WVALID  = 1'b1;
      check("start_awready", bus.AWREADY, 1);
      check("start_wready",  bus.WREADY,  1);
      @(negedge ACLK);
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
   endtask

   // Starts at k=1. Records pushes, waits for BVALID, holds BREADY low for
   // bdelay further cycles, then completes the B handshake. Returns on the
   // falling edge after that handshake.
   task automatic monitor(input int bdelay);
      m_vec = '0; m_data = '0; m_resp = '0;
      m_pcnt = 0; m_pcyc = -1; m_bcyc = -1; m_bad = 0;
      for (int k = 1; k <= LIMIT; k++) begin
         if (bus.AWREADY || bus.WREADY) m_bad++;
         if (ch_wr_en != 4'b0000) begin
            m_vec  = m_vec | ch_wr_en;
            m_data = ch_wdata;
            m_pcnt++;
            m_pcyc = k;
         end
         if (bus.BVALID) begin
            m_resp = bus.BRESP;
            m_bcyc = k;
            for (int d = 0; d < bdelay; d++) begin
               @(negedge ACLK);
               if (!bus.BVALID || bus.BRESP !== m_resp || bus.AWREADY || bus.WREADY)
                  m_bad++;
            end
            bus.BREADY = 1'b1;
            @(negedge ACLK);
            bus.BREADY = 1'b0;
            break;
         end
         @(negedge ACLK);
      end
      check("bvalid_seen", m_bcyc > 0, 1);
   endtask

   initial begin
      logic exp_okay;
      int   idle_evts;

      vecs[0]  = '{4'b0000, BASE + 32'd8,  32'hA5A5_0001, 4'hF,    4'b0100, OKAY};
      vecs[1]  = '{4'b0000, BASE,          32'h1111_0000, 4'hF,    4'b0001, OKAY};
      vecs[2]  = '{4'b0000, BASE + 32'd4,  32'h2222_0004, 4'hF,    4'b0010, OKAY};
      vecs[3]  = '{4'b0000, BASE + 32'd12, 32'h3333_000C, 4'hF,    4'b1000, OKAY};
      vecs[4]  = '{4'b0000, BASE + 32'd16, 32'hDEAD_0010, 4'hF,    4'b0000, DECERR};
      vecs[5]  = '{4'b0000, BASE + 32'd2,  32'hDEAD_0002, 4'hF,    4'b0000, DECERR};
      vecs[6]  = '{4'b0000, BASE + 32'd4,  32'hDEAD_0011, 4'b0011, 4'b0000, SLVERR};
      vecs[7]  = '{4'b0000, BASE - 32'd4,  32'hDEAD_0FFC, 4'hF,    4'b0000, DECERR};
      vecs[8]  = '{4'b0000, BASE + 32'd6,  32'hDEAD_0006, 4'b0001, 4'b0000, DECERR};
      vecs[9]  = '{4'b1101, BASE + 32'd4,  32'h4444_0004, 4'hF,    4'b0010, OKAY};
      vecs[10] = '{4'b0000, 32'hFFFF_FFFC, 32'hDEAD_FFFC, 4'hF,    4'b0000, DECERR};

      bus.AWADDR = '0; bus.AWVALID = 1'b0;
      bus.WDATA  = '0; bus.WSTRB   = '0; bus.WVALID = 1'b0;
      bus.BREADY = 1'b0;

      // ---- reset state
      ARESET = 1'b1;
      repeat (3) @(negedge ACLK);
      ARESET = 1'b0;
      @(negedge ACLK);
      check("rst_awready", bus.AWREADY, 1);
      check("rst_wready",  bus.WREADY,  1);
      check("rst_bvalid",  bus.BVALID,  0);
      check("rst_bresp",   bus.BRESP,   2'b00);
      check("rst_wr_en",   ch_wr_en,    4'b0000);
      check("rst_wdata",   ch_wdata,    32'h0);
      check("rst_errcnt",  err_count,   16'h0);

      // ---- table of single writes, AW and W in the same cycle
      for (int i = 0; i < 11; i++) begin
         ch_full = vecs[i].full;
         start_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
         monitor(0);
         ch_full  = 4'b0000;
         exp_okay = (vecs[i].exp_resp == OKAY);
         if (!exp_okay) err_exp++;
         check($sformatf("v%0d_resp", i),   m_resp, vecs[i].exp_resp);
         check($sformatf("v%0d_vec", i),    m_vec,  vecs[i].exp_vec);
         check($sformatf("v%0d_npush", i),  m_pcnt, exp_okay ? 1 : 0);
         check($sformatf("v%0d_blat", i),   m_bcyc, exp_okay ? 4 : 3);
         check($sformatf("v%0d_ready", i),  m_bad,  0);
         check($sformatf("v%0d_errcnt", i), err_count, err_exp);
         if (exp_okay) begin
            check($sformatf("v%0d_data", i), m_data, vecs[i].data);
            check($sformatf("v%0d_plat", i), m_pcyc, 3);
         end
      end
      check("wdata_hold", ch_wdata, vecs[10].data);

      // ---- W three cycles ahead of AW; a second W waits for the B handshake
      bus.WDATA  = 32'hCAFE_0000;
      bus.WSTRB  = 4'hF;
      bus.WVALID = 1'b1;
      check("A_wready_first", bus.WREADY, 1);
      @(negedge ACLK);
      bus.WDATA = 32'hBEEF_1111;
      for (int c = 0; c < 3; c++) begin
         check("A_wready_held", bus.WREADY, 0);
         check("A_wdata_held",  ch_wdata,   32'hCAFE_0000);
         @(negedge ACLK);
      end
      bus.AWADDR  = BASE;
      bus.AWVALID = 1'b1;
      check("A_awready", bus.AWREADY, 1);
      @(negedge ACLK);
      bus.AWVALID = 1'b0;
      monitor(0);
      check("A_resp",  m_resp, OKAY);
      check("A_vec",   m_vec,  4'b0001);
      check("A_data",  m_data, 32'hCAFE_0000);
      check("A_npush", m_pcnt, 1);
      check("A_ready", m_bad,  0);
      check("A_wready_after_b", bus.WREADY, 1);
      check("A_wdata_after_b",  ch_wdata,   32'hCAFE_0000);
      bus.AWADDR  = BASE + 32'd4;
      bus.AWVALID = 1'b1;
      @(negedge ACLK);
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      monitor(0);
      check("A2_resp", m_resp, OKAY);
      check("A2_vec",  m_vec,  4'b0010);
      check("A2_data", m_data, 32'hBEEF_1111);

      // ---- ch1 full until cycle 11: push lands in the cycle full drops
      ch_full = 4'b0010;
      start_write(BASE + 32'd4, 32'h5555_0001, 4'hF);
      fork
         monitor(0);
         begin
            repeat (10) @(posedge ACLK);
            #2 ch_full = 4'b0000;
         end
      join
      check("B_resp",  m_resp, OKAY);
      check("B_vec",   m_vec,  4'b0010);
      check("B_npush", m_pcnt, 1);
      check("B_plat",  m_pcyc, 11);
      check("B_blat",  m_bcyc, 12);
      check("B_data",  m_data, 32'h5555_0001);

      // ---- ch1 full for 300 cycles: SLVERR after 256 stall cycles, no push
      ch_full = 4'b0010;
      start_write(BASE + 32'd4, 32'h6666_0001, 4'hF);
      fork
         monitor(0);
         begin
            repeat (300) @(posedge ACLK);
            #2 ch_full = 4'b0000;
         end
      join
      @(negedge ACLK);
      err_exp++;
      check("C_resp",   m_resp, SLVERR);
      check("C_npush",  m_pcnt, 0);
      check("C_blat",   m_bcyc, 259);
      check("C_errcnt", err_count, err_exp);

      // ---- full drops in the stall cycle that would hit the timeout: push wins
      ch_full = 4'b0010;
      start_write(BASE + 32'd4, 32'h7777_0001, 4'hF);
      fork
         monitor(0);
         begin
            repeat (257) @(posedge ACLK);
            #2 ch_full = 4'b0000;
         end
      join
      check("D_resp",   m_resp, OKAY);
      check("D_npush",  m_pcnt, 1);
      check("D_plat",   m_pcyc, 258);
      check("D_errcnt", err_count, err_exp);

      // ---- BREADY held low: BVALID/BRESP stable, no ready
      start_write(BASE + 32'd12, 32'h8888_000C, 4'hF);
      monitor(4);
      check("E_resp",   m_resp, OKAY);
      check("E_vec",    m_vec,  4'b1000);
      check("E_stable", m_bad,  0);

      // ---- reset while stalled in PUSH abandons the transaction
      ch_full = 4'b0100;
      start_write(BASE + 32'd8, 32'h9999_0008, 4'hF);
      repeat (4) @(negedge ACLK);
      check("F_stalled", ch_wr_en, 4'b0000);
      check("F_errcnt_pre", err_count, err_exp);
      ARESET = 1'b1;
      @(negedge ACLK);
      check("F_bvalid",  bus.BVALID,  0);
      check("F_wr_en",   ch_wr_en,    4'b0000);
      check("F_awready", bus.AWREADY, 1);
      check("F_wready",  bus.WREADY,  1);
      check("F_errcnt",  err_count,   16'h0);
      check("F_wdata",   ch_wdata,    32'h0);
      ARESET  = 1'b0;
      ch_full = 4'b0000;
      idle_evts = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge ACLK);
         if (ch_wr_en != 4'b0000 || bus.BVALID) idle_evts++;
      end
      check("F_abandon", idle_evts, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
